// File: rtl/lfsr_ber_sequencer.sv
// lfsr_ber_sequencer: sequences one LFSR/comparator measurement run.
// Accepts a start request and latches the run parameters. It loads the seed into an external
// LFSR and then counts samples and comparator hits for the requested number of samples.
// Results stay on the outputs until the next run is accepted.
//
// Optional feature (define LFSR_LOCKUP_DETECT_EN): abort the run with err=1 when the LFSR
// value repeats between consecutive samples (stuck LFSR). Without it, err is tied low and
// every run takes exactly length samples.
//
// Reset is synchronous and active high. The port keeps its historical name rst_n.

module lfsr_ber_sequencer #(
  parameter int unsigned N = 8,
  parameter int unsigned L = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] seed_in,
  input  logic [N-1:0] target_in,
  input  logic [L-1:0] length_in,
  output logic         lfsr_load,
  output logic [N-1:0] lfsr_seed,
  output logic [N-1:0] cmp_target,
  input  logic [N-1:0] lfsr_out,
  input  logic         ber_in,
  output logic         busy,
  output logic         done,
  output logic [L-1:0] sample_count,
  output logic [L-1:0] hit_count,
  output logic         err
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0] seed_q, target_q;
  logic [L-1:0] length_q;
  logic [L-1:0] sample_q, hit_q;

  logic accept;
  logic last_sample;
  logic lock_hit;

  assign accept      = (state_q == StIdle) && start;
  // The sample taken this cycle is the last one once the count reaches length
  assign last_sample = ((sample_q + L'(1)) == length_q);

`ifdef LFSR_LOCKUP_DETECT_EN
  logic [N-1:0] prev_q;
  logic         err_q;

  // The first sample has no predecessor, so the compare starts at the second sample
  assign lock_hit = (state_q == StRun) && (sample_q != '0) && (lfsr_out == prev_q);

  // Previous-sample register and sticky lockup flag
  always_ff @(posedge clk) begin
    if (rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
      end else if (lock_hit) begin
        err_q <= 1'b1;
      end
      if (state_q == StRun) begin
        prev_q <= lfsr_out;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_lfsr_out;

  // The LFSR value is only needed for lockup detection
  assign unused_lfsr_out = ^lfsr_out;
  assign lock_hit        = 1'b0;
  assign err             = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = (length_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (last_sample || lock_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    lfsr_load = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StLoad: begin
        lfsr_load = 1'b1;
        busy      = 1'b1;
      end
      StRun: begin
        busy = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Run parameters latched on accept, counters cleared on accept and stepped in RUN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      seed_q   <= '0;
      target_q <= '0;
      length_q <= '0;
      sample_q <= '0;
      hit_q    <= '0;
    end else begin
      if (accept) begin
        seed_q   <= seed_in;
        target_q <= target_in;
        length_q <= length_in;
        sample_q <= '0;
        hit_q    <= '0;
      end else if (state_q == StRun) begin
        sample_q <= sample_q + L'(1);
        hit_q    <= hit_q + L'(ber_in);
      end
    end
  end

  assign lfsr_seed    = seed_q;
  assign cmp_target   = target_q;
  assign sample_count = sample_q;
  assign hit_count    = hit_q;

endmodule

// File: tb/tb_lfsr_ber_sequencer.sv
// Bench for lfsr_ber_sequencer with an external 8-bit XNOR LFSR (taps 7,5,4,3) and comparator.

module tb_lfsr_ber_sequencer;

  localparam int unsigned N = 8;
  localparam int unsigned L = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] seed_in = '0;
  logic [N-1:0] target_in = '0;
  logic [L-1:0] length_in = '0;
  logic         lfsr_load;
  logic [N-1:0] lfsr_seed;
  logic [N-1:0] cmp_target;
  logic [N-1:0] lfsr = '0;
  logic         ber;
  logic         busy;
  logic         done;
  logic [L-1:0] sample_count;
  logic [L-1:0] hit_count;
  logic         err;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [N-1:0] samples[$];

  always #5 clk = ~clk;

  lfsr_ber_sequencer #(
    .N(N),
    .L(L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .seed_in     (seed_in),
    .target_in   (target_in),
    .length_in   (length_in),
    .lfsr_load   (lfsr_load),
    .lfsr_seed   (lfsr_seed),
    .cmp_target  (cmp_target),
    .lfsr_out    (lfsr),
    .ber_in      (ber),
    .busy        (busy),
    .done        (done),
    .sample_count(sample_count),
    .hit_count   (hit_count),
    .err         (err)
  );

  // External LFSR and comparator
  always @(posedge clk) begin
    if (lfsr_load) lfsr <= lfsr_seed;
    else           lfsr <= {lfsr[6:0], ~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3])};
  end
  assign ber = (cmp_target >= lfsr);

  always @(negedge clk) if (done) done_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run; exp_lat < 0 skips the latency compare
  task automatic do_run(input string tag, input logic [7:0] seed, input logic [7:0] target,
                        input logic [15:0] len, input int exp_lat, input int exp_sc,
                        input int exp_hc, input int exp_err);
    int n;
    bit seen;
    @(negedge clk);
    seed_in = seed; target_in = target; length_in = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check_eq($sformatf("%s_load", tag), 32'(lfsr_load), 32'd1);
    check_eq($sformatf("%s_busy_load", tag), 32'(busy), 32'd1);
    check_eq($sformatf("%s_seed_out", tag), 32'(lfsr_seed), 32'(seed));
    samples.delete();
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy && !lfsr_load) samples.push_back(lfsr);
        @(negedge clk);
        n++;
      end
    end
    check_eq($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
    if (exp_lat >= 0) check_eq($sformatf("%s_latency", tag), 32'(n), 32'(exp_lat));
    check_eq($sformatf("%s_busy_done", tag), 32'(busy), 32'd1);
    check_eq($sformatf("%s_samples", tag), 32'(sample_count), 32'(exp_sc));
    check_eq($sformatf("%s_hits", tag), 32'(hit_count), 32'(exp_hc));
    check_eq($sformatf("%s_err", tag), 32'(err), 32'(exp_err));
    @(negedge clk);
    check_eq($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    check_eq($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
    check_eq($sformatf("%s_samples_hold", tag), 32'(sample_count), 32'(exp_sc));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp1[10];
    int d0;
    int dones[$];
    int k;
    exp1 = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd30, 8'd61, 8'd122, 8'd244, 8'd232, 8'd208};

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_load", 32'(lfsr_load), 32'd0);
    check_eq("rst_sc", 32'(sample_count), 32'd0);
    check_eq("rst_hc", 32'(hit_count), 32'd0);
    check_eq("rst_seed", 32'(lfsr_seed), 32'd0);
    check_eq("rst_target", 32'(cmp_target), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // 1: nominal run, sample sequence checked too
    do_run("t1", 8'd1, 8'd85, 16'd10, 12, 10, 6, 0);
    check_eq("t1_nsamples", 32'(samples.size()), 32'd10);
    for (int i = 0; i < 10 && i < samples.size(); i++)
      check_eq($sformatf("t1_sample%0d", i), 32'(samples[i]), 32'(exp1[i]));

    // 2: zero length, counts cleared from previous run
    do_run("t2", 8'd77, 8'd85, 16'd0, 2, 0, 0, 0);

    // 3: all hits, start pulse during RUN ignored
    d0 = done_count;
    @(negedge clk);
    seed_in = 8'd1; target_in = 8'd255; length_in = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("t3_done_count", 32'(done_count - d0), 32'd1);
    check_eq("t3_samples", 32'(sample_count), 32'd5);
    check_eq("t3_hits", 32'(hit_count), 32'd5);
    check_eq("t3_busy", 32'(busy), 32'd0);

    // 4: reset at 3rd RUN cycle
    d0 = done_count;
    @(negedge clk);
    seed_in = 8'd1; target_in = 8'd85; length_in = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_sc", 32'(sample_count), 32'd0);
    check_eq("t4_hc", 32'(hit_count), 32'd0);
    check_eq("t4_load", 32'(lfsr_load), 32'd0);
    repeat (14) @(negedge clk);
    check_eq("t4_no_done", 32'(done_count - d0), 32'd0);
    do_run("t4r", 8'd1, 8'd85, 16'd10, 12, 10, 6, 0);

    // 5: stuck all-ones LFSR
`ifdef LFSR_LOCKUP_DETECT_EN
    do_run("t5", 8'hFF, 8'd85, 16'd4, -1, 2, 0, 1);
`else
    do_run("t5", 8'hFF, 8'd85, 16'd4, 6, 4, 0, 0);
`endif

    // 6: start held high, back-to-back runs
    @(negedge clk);
    seed_in = 8'd1; target_in = 8'd85; length_in = 16'd3; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        dones.push_back(c);
        check_eq($sformatf("t6_sc_%0d", c), 32'(sample_count), 32'd3);
        check_eq($sformatf("t6_hc_%0d", c), 32'(hit_count), 32'd3);
      end
    end
    start = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_idle", 32'(busy), 32'd0);
    check_eq("t6_ndone", 32'(dones.size()), 32'd5);
    if (dones.size() > 0) check_eq("t6_first", 32'(dones[0]), 32'd5);
    for (int i = 1; i < dones.size(); i++)
      check_eq($sformatf("t6_period%0d", i), 32'(dones[i] - dones[i-1]), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
